// File: rtl/state_line_streamer_pkg.sv
// Shared definitions for the state-line streaming stage: geometry defaults
// used by the controller and memory, plus the streamer FSM encoding.
package state_line_streamer_pkg;

   localparam int DEF_LINE_W    = 25;
   localparam int DEF_NUM_LINES = 64;
   localparam int DEF_ADDR_W    = 6;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_FIN   = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      FETCH = ST_FETCH,
      DRAIN = ST_DRAIN,
      FIN   = ST_FIN
   } state_t;

endpackage

// File: rtl/line_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; the head entry is always visible on dout.
// A push and a pop in the same cycle leave the occupancy unchanged.
module line_skid_fifo
   import state_line_streamer_pkg::*;
#(
   parameter int W = DEF_LINE_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         empty,
   output logic         full
);

   logic [W-1:0] slot [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (count == 2'd0);
   assign full    = (count == 2'd2);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = slot[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot[0] <= '0;
         slot[1] <= '0;
         rd_ptr  <= 1'b0;
         wr_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (do_push) begin
            slot[wr_ptr] <= din;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/state_line_streamer.sv
// Reads the state memory line by line after a permutation completes and streams
// each line out over valid/ready, using a 2-entry skid FIFO for read latency.
module state_line_streamer
   import state_line_streamer_pkg::*;
#(
   parameter int LINE_W    = DEF_LINE_W,
   parameter int NUM_LINES = DEF_NUM_LINES,
   parameter int ADDR_W    = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_data,
   output logic [LINE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LINES - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] addr;
   logic              inflight;
   logic [1:0]        fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic              pop;
   logic [2:0]        occupancy;
   logic              issue_ok;

   assign mem_addr  = addr;
   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};

   // A pop this cycle frees a slot, so a read may still issue at occupancy 2;
   // that keeps one line per cycle flowing when the sink never stalls.
   assign issue_ok  = (occupancy < 3'd2) | (pop & ~(fifo_full & inflight));

   line_skid_fifo #(.W(LINE_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .din   (mem_data),
      .pop   (pop),
      .dout  (out_data),
      .count (fifo_count),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   always_comb begin
      state_nxt = state;
      mem_read  = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            if (start)
               state_nxt = FETCH;
         end
         FETCH: begin
            mem_read = issue_ok;
            if (issue_ok && addr == LAST_ADDR)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (!inflight && fifo_empty)
               state_nxt = FIN;
         end
         FIN: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The address parks on the last line once it has been read and only
   // returns to zero when a new frame is started.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         addr     <= '0;
         inflight <= 1'b0;
      end else begin
         state    <= state_nxt;
         inflight <= mem_read;
         if (state == IDLE && start)
            addr <= '0;
         else if (mem_read && addr != LAST_ADDR)
            addr <= addr + 1'b1;
      end
   end

endmodule

// File: tb/tb_state_line_streamer.sv
// Self-checking bench for state_line_streamer: a line-ordered scoreboard checks every
// transfer, read address and credit bound while directed frames exercise stalls and resets.
module tb_state_line_streamer;
   import state_line_streamer_pkg::*;

   localparam int LW = DEF_LINE_W;
   localparam int NL = DEF_NUM_LINES;
   localparam int AW = DEF_ADDR_W;

   logic          clk       = 1'b0;
   logic          rst       = 1'b0;
   logic          start     = 1'b0;
   logic          out_ready = 1'b0;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_data  = '0;
   logic [LW-1:0] out_data;
   logic          out_valid;
   logic          busy;
   logic          done;

   logic [LW-1:0] mem [NL];

   int vectors      = 0;
   int miscompares  = 0;
   int exp_idx      = 0;
   int reads_issued = 0;
   int done_cnt     = 0;
   int ready_mode   = 0;
   int phase        = 0;

   logic          stalled = 1'b0;
   logic [LW-1:0] stall_data = '0;

   always #5 clk = ~clk;

   state_line_streamer dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done)
   );

   // State memory: synchronous read, data valid the cycle after the strobe.
   always @(posedge clk)
      if (mem_read)
         mem_data <= mem[mem_addr];

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Sink ready pattern: 0 always, 1 pattern 1,0,0,1, 2 hold low, 3 random.
   always @(posedge clk) begin
      #1;
      phase++;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ((phase % 4) == 0) || ((phase % 4) == 3);
         2:       out_ready = 1'b0;
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   // Scoreboard: lines must leave in ascending order, reads ascend from 0,
   // and lines read but not yet delivered never exceed the two FIFO slots.
   always @(negedge clk) begin
      if (!rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check_output("stall_valid", 32'(out_valid), 32'd1);
            check_output("stall_data", 32'(out_data), 32'(stall_data));
         end
         if (out_valid && out_ready) begin
            if (exp_idx < NL)
               check_output("data", 32'(out_data), 32'(mem[exp_idx]));
            else
               check_output("extra_line", 32'(exp_idx), 32'(NL - 1));
            exp_idx++;
         end
         if (mem_read) begin
            check_output("read_addr", 32'(mem_addr), 32'(reads_issued));
            check_output("credit", 32'((reads_issued + 1 - exp_idx) <= 2), 32'd1);
            reads_issued++;
         end
         if (done) begin
            check_output("done_all_lines", 32'(exp_idx), 32'(NL));
            done_cnt++;
         end
         stalled    = out_valid && !out_ready;
         stall_data = out_data;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_frame();
      exp_idx      = 0;
      reads_issued = 0;
   endtask

   task automatic apply_stimulus_start();
      start = 1'b1;
      clear_frame();
      step();
      start = 1'b0;
   endtask

   task automatic wait_idx(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_idx >= target)
            break;
         step();
      end
      check_output("reach_idx", 32'(exp_idx), 32'(target));
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (done)
            break;
         step();
      end
      check_output("done_seen", 32'(done), 32'd1);
   endtask

   task automatic load_random();
      for (int k = 0; k < NL; k++)
         mem[k] = LW'($urandom);
   endtask

   initial begin
      // Reset state
      step();
      step();
      check_output("rst_valid", 32'(out_valid), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_read", 32'(mem_read), 32'd0);
      check_output("rst_addr", 32'(mem_addr), 32'd0);
      rst = 1'b1;
      step();

      // Free flow with line k = 3k+1
      for (int k = 0; k < NL; k++)
         mem[k] = LW'(3 * k + 1);
      ready_mode = 0;
      step();
      apply_stimulus_start();
      step();
      check_output("first_valid_early", 32'(out_valid), 32'd0);
      check_output("busy_after_start", 32'(busy), 32'd1);
      step();
      for (int i = 0; i < NL; i++) begin
         check_output("free_flow_valid", 32'(out_valid), 32'd1);
         step();
      end
      check_output("tail_valid", 32'(out_valid), 32'd0);
      check_output("done_early", 32'(done), 32'd0);
      step();
      check_output("done_timing", 32'(done), 32'd1);
      step();
      check_output("done_width", 32'(done), 32'd0);
      check_output("idle_busy", 32'(busy), 32'd0);
      check_output("done_count_1", 32'(done_cnt), 32'd1);

      // Back-pressure 1,0,0,1
      load_random();
      ready_mode = 1;
      apply_stimulus_start();
      wait_done(600);
      check_output("done_count_2", 32'(done_cnt), 32'd2);
      step();

      // Stall at the end of the frame
      load_random();
      ready_mode = 0;
      apply_stimulus_start();
      wait_idx(62, 200);
      ready_mode = 2;
      for (int i = 0; i < 10; i++) begin
         step();
         check_output("end_stall_read", 32'(mem_read), 32'd0);
         check_output("end_stall_valid", 32'(out_valid), 32'd1);
         check_output("end_stall_busy", 32'(busy), 32'd1);
      end
      ready_mode = 0;
      wait_done(100);
      check_output("done_count_3", 32'(done_cnt), 32'd3);
      step();

      // start while busy, random sink
      load_random();
      ready_mode = 3;
      apply_stimulus_start();
      wait_idx(20, 300);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_done(800);
      for (int i = 0; i < 6; i++) begin
         step();
         check_output("no_restart_busy", 32'(busy), 32'd0);
         check_output("no_restart_valid", 32'(out_valid), 32'd0);
      end
      check_output("done_count_4", 32'(done_cnt), 32'd4);

      // Reset mid-frame with a read in flight
      load_random();
      ready_mode = 0;
      apply_stimulus_start();
      wait_idx(30, 200);
      rst = 1'b0;
      #1;
      check_output("mid_rst_valid", 32'(out_valid), 32'd0);
      check_output("mid_rst_busy", 32'(busy), 32'd0);
      check_output("mid_rst_read", 32'(mem_read), 32'd0);
      check_output("mid_rst_addr", 32'(mem_addr), 32'd0);
      step();
      step();
      rst = 1'b1;
      clear_frame();
      step();
      apply_stimulus_start();
      wait_done(200);
      check_output("done_count_5", 32'(done_cnt), 32'd5);

      // Back-to-back frames
      step();
      apply_stimulus_start();
      wait_done(200);
      check_output("b2b_fin_busy", 32'(busy), 32'd1);
      step();
      check_output("b2b_idle_busy", 32'(busy), 32'd0);
      start = 1'b1;
      clear_frame();
      step();
      start = 1'b0;
      check_output("b2b_restart_busy", 32'(busy), 32'd1);
      wait_done(200);
      check_output("done_count_7", 32'(done_cnt), 32'd7);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
